// File: rtl/pc_sequencer_if.sv
// Fetch, register-file read and execute-issue signals between the sequencer
// (master) and the memory/datapath side (slave).
interface pc_sequencer_if;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [2:0]  rf_ra;
  logic [2:0]  rf_rb;
  logic [7:0]  rf_rd_a;
  logic [7:0]  rf_rd_b;
  logic        ex_valid;
  logic [15:0] ex_instr;
  logic        ex_done;

  modport master (
    output imem_req, imem_addr, rf_ra, rf_rb, ex_valid, ex_instr,
    input  imem_ack, imem_data, rf_rd_a, rf_rd_b, ex_done
  );

  modport slave (
    input  imem_req, imem_addr, rf_ra, rf_rb, ex_valid, ex_instr,
    output imem_ack, imem_data, rf_rd_a, rf_rd_b, ex_done
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches one instruction at a time, resolves
// branches/jumps locally and issues everything else to the datapath.
//
// state  | meaning
// IDLE   | waiting for run at an instruction boundary
// FETCH  | imem_req high, waiting for imem_ack
// DECODE | ir valid, register reads presented, branch outcome resolved
// BRANCH | br_taken valid, pc redirected at end of cycle
// EXWAIT | ex_valid high, waiting for ex_done
// HALT   | halted, left only through reset
module pc_sequencer (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  pc_sequencer_if.master       bus,
  output logic [7:0]           pc,
  output logic                 br_taken,
  output logic                 halted
);
  localparam logic [4:0] OP_BNE  = 5'b10011;
  localparam logic [4:0] OP_BE   = 5'b10100;
  localparam logic [4:0] OP_BNER = 5'b10101;
  localparam logic [4:0] OP_BER  = 5'b10110;
  localparam logic [4:0] OP_J    = 5'b10111;
  localparam logic [4:0] OP_JR   = 5'b11000;
  localparam logic [4:0] OP_HLT  = 5'b11111;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, BRANCH, EXWAIT, HALT} state_t;

  state_t      state;
  logic [15:0] ir;
  logic [7:0]  br_target;
  logic        imem_req_q;
  logic        ex_valid_q;
  logic [7:0]  pc_inc;
  logic        a_nz;
  logic        is_branch;
  logic        take;
  logic [7:0]  target;

  assign pc_inc        = pc + 8'd1;
  assign a_nz          = |bus.rf_rd_a;
  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = pc;
  assign bus.rf_ra     = ir[10:8];
  assign bus.rf_rb     = ir[7:5];
  assign bus.ex_valid  = ex_valid_q;
  assign bus.ex_instr  = ir;

  // Branch outcome is resolved while DECODE presents the register reads so
  // that br_taken can be a registered pulse aligned with the BRANCH cycle.
  always_comb begin
    is_branch = 1'b1;
    take      = 1'b0;
    target    = ir[7:0];
    case (ir[15:11])
      OP_BNE:  take = a_nz;
      OP_BE:   take = !a_nz;
      OP_BNER: begin take = a_nz;  target = bus.rf_rd_b; end
      OP_BER:  begin take = !a_nz; target = bus.rf_rd_b; end
      OP_J:    take = 1'b1;
      OP_JR:   begin take = 1'b1;  target = bus.rf_rd_a; end
      default: is_branch = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= 8'h00;
      ir         <= 16'h0000;
      br_target  <= 8'h00;
      imem_req_q <= 1'b0;
      ex_valid_q <= 1'b0;
      br_taken   <= 1'b0;
      halted     <= 1'b0;
    end else begin
      br_taken <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            state      <= FETCH;
            imem_req_q <= 1'b1;
          end
        end
        FETCH: begin
          if (bus.imem_ack) begin
            ir         <= bus.imem_data;
            imem_req_q <= 1'b0;
            state      <= DECODE;
          end
        end
        DECODE: begin
          if (ir[15:11] == OP_HLT) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (is_branch) begin
            state     <= BRANCH;
            br_taken  <= take;
            br_target <= take ? target : pc_inc;
          end else begin
            state      <= EXWAIT;
            ex_valid_q <= 1'b1;
          end
        end
        BRANCH: begin
          pc         <= br_target;
          state      <= run ? FETCH : IDLE;
          imem_req_q <= run;
        end
        EXWAIT: begin
          if (bus.ex_done) begin
            ex_valid_q <= 1'b0;
            pc         <= pc_inc;
            state      <= run ? FETCH : IDLE;
            imem_req_q <= run;
          end
        end
        HALT: ;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: acts as instruction memory, register file and
// datapath, and predicts each instruction's next pc with a small ISA model.
module tb_pc_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       run = 1'b0;
  logic [7:0] pc;
  logic       br_taken;
  logic       halted;
  logic [7:0] rf [8];
  logic [7:0] model_pc;
  int         checks = 0;
  int         failures = 0;

  pc_sequencer_if bus();

  assign bus.rf_rd_a = rf[bus.rf_ra];
  assign bus.rf_rd_b = rf[bus.rf_rb];

  pc_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .bus(bus),
    .pc(pc), .br_taken(br_taken), .halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // kind: 0 = issued to datapath, 1 = branch/jump, 2 = halt
  function automatic void isa_next(input logic [7:0] cur, input logic [15:0] ins,
                                   output int kind, output logic [7:0] nxt, output logic tk);
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] seq;
    a    = rf[ins[10:8]];
    b    = rf[ins[7:5]];
    seq  = cur + 8'd1;
    kind = 1;
    tk   = 1'b0;
    case (ins[15:11])
      5'b10011: tk = (a != 0);
      5'b10100: tk = (a == 0);
      5'b10101: tk = (a != 0);
      5'b10110: tk = (a == 0);
      5'b10111: tk = 1'b1;
      5'b11000: tk = 1'b1;
      5'b11111: kind = 2;
      default:  kind = 0;
    endcase
    nxt = seq;
    if (tk) begin
      case (ins[15:11])
        5'b10101, 5'b10110: nxt = b;
        5'b11000:           nxt = a;
        default:            nxt = ins[7:0];
      endcase
    end
  endfunction

  task automatic wait_req();
    int  n;
    logic from_idle;
    n = 0;
    from_idle = (bus.imem_req === 1'b0);
    if (from_idle) run = 1'b1;
    while (bus.imem_req !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("fetch_req", bus.imem_req, 1);
    if (from_idle) chk("idle_to_fetch_cycles", n, 1);
  endtask

  task automatic run_instr(input logic [15:0] ins, input logic run_after,
                           input int ex_lat, input int ack_dly);
    int         kind;
    logic [7:0] nxt;
    logic       tk;
    wait_req();
    chk("imem_addr", bus.imem_addr, model_pc);
    for (int i = 0; i < ack_dly; i++) begin
      run = 1'($urandom);
      tick();
      chk("req_hold", bus.imem_req, 1);
    end
    bus.imem_ack  = 1'b1;
    bus.imem_data = ins;
    tick();
    bus.imem_ack  = 1'b0;
    bus.imem_data = 16'($urandom);
    isa_next(model_pc, ins, kind, nxt, tk);
    chk("rf_ra", bus.rf_ra, ins[10:8]);
    chk("rf_rb", bus.rf_rb, ins[7:5]);
    chk("req_drop", bus.imem_req, 0);
    bus.ex_done = 1'($urandom);
    tick();
    bus.ex_done = 1'b0;
    if (kind == 2) begin
      chk("halted", halted, 1);
      for (int i = 0; i < 20; i++) begin
        run = 1'b1;
        tick();
        chk("halt_no_req", bus.imem_req, 0);
        chk("halt_no_issue", bus.ex_valid, 0);
        chk("halt_stays", halted, 1);
      end
      return;
    end
    if (kind == 1) begin
      chk("br_taken", br_taken, tk);
      chk("branch_no_issue", bus.ex_valid, 0);
      run = run_after;
      tick();
      chk("br_pulse_end", br_taken, 0);
    end else begin
      chk("ex_instr", bus.ex_instr, ins);
      for (int i = 0; i < ex_lat; i++) begin
        chk("ex_valid", bus.ex_valid, 1);
        chk("ex_no_req", bus.imem_req, 0);
        bus.imem_ack = 1'($urandom);
        run          = (i == ex_lat - 1) ? run_after : 1'($urandom);
        bus.ex_done  = (i == ex_lat - 1);
        tick();
      end
      bus.ex_done  = 1'b0;
      bus.imem_ack = 1'b0;
      chk("ex_valid_drop", bus.ex_valid, 0);
    end
    model_pc = nxt;
    chk("pc", pc, model_pc);
    chk("boundary_req", bus.imem_req, run_after);
    chk("not_halted", halted, 0);
  endtask

  function automatic logic [15:0] rand_instr();
    logic [4:0] op;
    case ($urandom % 8)
      0: op = 5'b10011;
      1: op = 5'b10100;
      2: op = 5'b10101;
      3: op = 5'b10110;
      4: op = 5'b10111;
      5: op = 5'b11000;
      default: op = {1'b0, 4'($urandom)};
    endcase
    return {op, 11'($urandom)};
  endfunction

  initial begin
    bus.imem_ack  = 1'b0;
    bus.imem_data = 16'h0000;
    bus.ex_done   = 1'b0;
    for (int i = 0; i < 8; i++) rf[i] = 8'h00;

    #2 rst = 1'b1;
    #1;
    chk("rst_pc", pc, 0);
    chk("rst_req", bus.imem_req, 0);
    chk("rst_ex_valid", bus.ex_valid, 0);
    chk("rst_br_taken", br_taken, 0);
    chk("rst_halted", halted, 0);
    chk("rst_ex_instr", bus.ex_instr, 0);
    chk("rst_rf_ra", bus.rf_ra, 0);
    chk("rst_rf_rb", bus.rf_rb, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("idle_no_req", bus.imem_req, 0);
    model_pc = 8'h00;

    // pc 0..4 issue, then J 0x40 at pc 5
    run_instr({5'b00001, 11'h123}, 1'b1, 2, 0);
    for (int i = 0; i < 4; i++) run_instr({5'b00010, 11'($urandom)}, 1'b1, 1, i % 3);
    run_instr({5'b10111, 3'd0, 8'h40}, 1'b1, 1, 0);
    run_instr({5'b10111, 3'd0, 8'h07}, 1'b1, 1, 1);

    rf[1] = 8'h00;
    rf[2] = 8'h03;
    rf[3] = 8'h99;
    rf[4] = 8'h10;
    run_instr({5'b10011, 3'd1, 8'h55}, 1'b1, 1, 0);
    run_instr({5'b10100, 3'd1, 8'h20}, 1'b1, 1, 0);
    run_instr({5'b10101, 3'd2, 3'd3, 5'h00}, 1'b1, 1, 0);
    run_instr({5'b11000, 3'd4, 8'h00}, 1'b0, 1, 0);
    run_instr({5'b10111, 3'd0, 8'hFF}, 1'b1, 1, 0);
    run_instr({5'b00111, 11'h7FF}, 1'b1, 3, 0);
    chk("wrap_pc", pc, 8'h00);

    for (int n = 0; n < 60; n++) begin
      for (int r = 0; r < 8; r++) rf[r] = ($urandom % 3 == 0) ? 8'h00 : 8'($urandom);
      run_instr(rand_instr(), 1'($urandom), 1 + int'($urandom % 4), int'($urandom % 3));
    end

    // async reset while EXWAIT sees ex_done
    run_instr({5'b10111, 3'd0, 8'h33}, 1'b1, 1, 0);
    wait_req();
    bus.imem_ack  = 1'b1;
    bus.imem_data = {5'b00100, 11'h0AA};
    tick();
    bus.imem_ack = 1'b0;
    tick();
    chk("pre_rst_ex_valid", bus.ex_valid, 1);
    chk("pre_rst_pc", pc, 8'h33);
    bus.ex_done = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pc", pc, 0);
    chk("async_rst_ex_valid", bus.ex_valid, 0);
    chk("async_rst_ex_instr", bus.ex_instr, 0);
    tick();
    bus.ex_done = 1'b0;
    run = 1'b0;
    rst = 1'b0;
    tick();
    chk("post_rst_pc", pc, 0);
    chk("post_rst_req", bus.imem_req, 0);
    model_pc = 8'h00;
    run_instr({5'b01000, 11'h155}, 1'b1, 1, 0);
    run_instr({5'b11111, 11'h000}, 1'b1, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
